// File: rtl/sos_decimator.sv
// sos_decimator: boxcar decimator placed after the biquad SOS filter stage.
// Each filter_done pulse captures one sample (data_in, on the following
// cycle). Every DECIM = 2^LOG2_DECIM samples are summed and divided by DECIM
// with an arithmetic shift (floor rounding). The mean is then queued in a
// small first-word-fall-through FIFO that drains over a valid/ready handshake.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   data_in      signed filtered sample, valid the cycle after filter_done
//   filter_done  one-cycle pulse from the filter stage
//   data_out     FIFO head (zero while empty)
//   out_valid    FIFO not empty
//   out_ready    consumer accepts data_out when out_valid && out_ready
//   overflow     sticky: a result was dropped because the FIFO was full
//   fill_level   number of FIFO entries held
//
// FSM states
//   state | meaning
//   IDLE  | waiting for filter_done
//   CAPT  | one cycle: sample data_in into the accumulator
module sos_decimator #(
  parameter int DATA_SIZE  = 24,
  parameter int LOG2_DECIM = 2,
  parameter int FIFO_AW    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [DATA_SIZE-1:0] data_in,
  input  logic                        filter_done,
  output logic signed [DATA_SIZE-1:0] data_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        overflow,
  output logic [FIFO_AW:0]            fill_level
);

  localparam int ACC_W = DATA_SIZE + LOG2_DECIM;
  localparam int CNT_W = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
  localparam int DECIM = 1 << LOG2_DECIM;
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic {IDLE, CAPT} state_t;

  state_t state_q, state_d;
  logic   capt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // filter_done during CAPT is ignored; the filter guarantees wider spacing.
  always_comb begin
    state_d = state_q;
    capt    = 1'b0;
    case (state_q)
      IDLE: if (filter_done) state_d = CAPT;
      CAPT: begin
        capt    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic signed [ACC_W-1:0]     acc_q, acc_next;
  logic [CNT_W-1:0]            cnt_q;
  logic                        last;
  logic signed [DATA_SIZE-1:0] result;

  // The accumulator is LOG2_DECIM bits wider than a sample, so a full group
  // cannot overflow, and the mean always fits back into DATA_SIZE bits.
  assign acc_next = acc_q + ACC_W'(data_in);
  assign last     = (cnt_q == CNT_W'(DECIM - 1));
  assign result   = DATA_SIZE'(acc_next >>> LOG2_DECIM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (capt) begin
      if (last) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        acc_q <= acc_next;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  logic signed [DATA_SIZE-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]          wr_ptr, rd_ptr;
  logic [FIFO_AW:0]            count_q;
  logic                        push, pop, full, wr_en, drop;

  assign push  = capt && last;
  assign pop   = out_valid && out_ready;
  assign full  = (count_q == (FIFO_AW+1)'(DEPTH));
  // A pop in the same cycle frees the head slot, so a full FIFO can still
  // accept the push.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= result;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !wr_en) count_q <= count_q - 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  assign out_valid  = (count_q != '0);
  assign data_out   = out_valid ? mem[rd_ptr] : '0;
  assign fill_level = count_q;

endmodule

// File: tb/tb_sos_decimator.sv
module tb_sos_decimator;

  localparam int DATA_SIZE  = 24;
  localparam int LOG2_DECIM = 2;
  localparam int FIFO_AW    = 2;
  localparam int DECIM      = 4;
  localparam int DEPTH      = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [DATA_SIZE-1:0] data_in = '0;
  logic                 filter_done = 1'b0;
  logic [DATA_SIZE-1:0] data_out;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic                 overflow;
  logic [FIFO_AW:0]     fill_level;

  int tests = 0;
  int fails = 0;
  int rdy_mode = 0;  // 0: hold low, 1: hold high, 2: random

  // reference model state
  logic [DATA_SIZE-1:0] exp_q[$];
  longint               samples[$];
  bit                   pending = 1'b0;
  bit                   ovf_m = 1'b0;

  sos_decimator #(
    .DATA_SIZE (DATA_SIZE),
    .LOG2_DECIM(LOG2_DECIM),
    .FIFO_AW   (FIFO_AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .filter_done(filter_done),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .fill_level (fill_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_SIZE-1:0] floor_mean(input longint s);
    longint m;
    m = s / DECIM;
    if ((s % DECIM) != 0 && s < 0) m = m - 1;
    return m[DATA_SIZE-1:0];
  endfunction

  // Scoreboard/monitor: compares the DUT against the model between edges,
  // then advances the model for the coming rising edge.
  always @(negedge clk) begin : monitor
    logic [DATA_SIZE-1:0] exp_d;
    logic [DATA_SIZE-1:0] res;
    longint               s;
    bit                   pop, push;
    if (!reset) begin
      exp_q.delete();
      samples.delete();
      pending = 1'b0;
      ovf_m   = 1'b0;
    end
    exp_d = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk("out_valid", out_valid, exp_q.size() > 0);
    chk("data_out", data_out, exp_d);
    chk("fill_level", fill_level, exp_q.size());
    chk("overflow", overflow, ovf_m);
    if (reset) begin
      pop  = (exp_q.size() > 0) && out_ready;
      push = 1'b0;
      res  = '0;
      if (pending) begin
        pending = 1'b0;
        samples.push_back(longint'($signed(data_in)));
        if (samples.size() == DECIM) begin
          s = 0;
          foreach (samples[i]) s += samples[i];
          res = floor_mean(s);
          samples.delete();
          push = 1'b1;
        end
      end else if (filter_done) begin
        pending = 1'b1;
      end
      if (push && exp_q.size() == DEPTH && !pop) begin
        ovf_m = 1'b1;
      end else begin
        if (pop)  void'(exp_q.pop_front());
        if (push) exp_q.push_back(res);
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic set_rdy(input int m);
    @(posedge clk);
    #2;
    rdy_mode = m;
    if (m < 2) out_ready = m[0];
  endtask

  task automatic send(input int v, input int extra, input bit pop_now);
    int junk;
    junk = int'($urandom);
    @(posedge clk);
    #1;
    filter_done = 1'b1;
    data_in     = junk[DATA_SIZE-1:0];
    @(posedge clk);
    #1;
    filter_done = 1'b0;
    data_in     = v[DATA_SIZE-1:0];
    if (pop_now) out_ready = 1'b1;
    @(posedge clk);
    #1;
    if (pop_now) out_ready = 1'b0;
    repeat (extra) @(posedge clk);
  endtask

  task automatic group(input int a, input int b, input int c, input int d);
    send(a, 0, 1'b0);
    send(b, 0, 1'b0);
    send(c, 0, 1'b0);
    send(d, 0, 1'b0);
  endtask

  task automatic drain();
    set_rdy(1);
    repeat (6) @(posedge clk);
    set_rdy(0);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", data_out, 24'h0);
    chk("rst_fill", fill_level, 3'd0);
    chk("rst_ovf", overflow, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;

    group(1000, 1000, 1000, 1000);
    @(negedge clk);
    chk("const_valid", out_valid, 1'b1);
    chk("const_data", data_out, 24'd1000);
    chk("const_fill", fill_level, 3'd1);
    drain();

    group(-3, -2, -1, -1);
    @(negedge clk);
    chk("floor_neg", data_out, 24'hFFFFFE);
    drain();
    group(1, 1, 1, 2);
    @(negedge clk);
    chk("floor_pos", data_out, 24'd1);
    drain();

    group('h7FFFFF, 'h7FFFFF, 'h7FFFFF, 'h7FFFFF);
    @(negedge clk);
    chk("ext_max", data_out, 24'h7FFFFF);
    drain();
    group('h800000, 'h800000, 'h800000, 'h800000);
    @(negedge clk);
    chk("ext_min", data_out, 24'h800000);
    drain();
    group('h7FFFFF, 'h800000, 'h7FFFFF, 'h800000);
    @(negedge clk);
    chk("ext_alt", data_out, 24'hFFFFFF);
    drain();

    for (int v = 1; v <= 5; v++) group(v, v, v, v);
    @(negedge clk);
    chk("bp_fill", fill_level, 3'd4);
    chk("bp_ovf", overflow, 1'b1);
    chk("bp_head", data_out, 24'd1);
    set_rdy(1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("bp_empty", out_valid, 1'b0);
    chk("bp_ovf_sticky", overflow, 1'b1);
    set_rdy(0);

    reset_pulse();
    for (int v = 5; v <= 8; v++) group(v, v, v, v);
    send(9, 0, 1'b0);
    send(9, 0, 1'b0);
    send(9, 0, 1'b0);
    send(9, 0, 1'b1);
    @(negedge clk);
    chk("full_fill", fill_level, 3'd4);
    chk("full_ovf", overflow, 1'b0);
    chk("full_head", data_out, 24'd6);
    drain();

    send(100, 0, 1'b0);
    send(100, 0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rstm_valid", out_valid, 1'b0);
    chk("rstm_fill", fill_level, 3'd0);
    chk("rstm_data", data_out, 24'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    group(8, 8, 8, 8);
    @(negedge clk);
    chk("rstm_result", data_out, 24'd8);
    chk("rstm_count", fill_level, 3'd1);
    chk("rstm_ovf", overflow, 1'b0);
    drain();

    set_rdy(2);
    repeat (300) send(int'($urandom), int'($urandom_range(0, 3)), 1'b0);
    set_rdy(1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("final_empty", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
